clock_freq_calc: RTL and testbench

//  Post-processing stage fed by the clock-counter measurement block in the AFU.

---
 rtl/clock_freq_calc_if.sv | 34 +++
 rtl/clock_freq_calc.sv | 192 +++++++++++++++++++
 tb/tb_clock_freq_calc.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clock_freq_calc_if.sv
// Request/response bundle between the clock-counter post-processing stage and
// its requester (normally the MMIO CSR block).
//   start, abort              request and cancel controls
//   count, ref_count, ref_freq operands, sampled only when a request is accepted
//   busy, done                status; done is a one-cycle completion pulse
//   result, div_by_zero,      frequency in MHz plus its status flags, held
//   overflow                  until the next completion
// The master modport drives requests. The slave modport is the calculator.
interface clock_freq_calc_if #(
    parameter int CNT_W  = 64,
    parameter int FREQ_W = 16,
    parameter int OUT_W  = 32
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  ref_count;
    logic [FREQ_W-1:0] ref_freq;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  result;
    logic              div_by_zero;
    logic              overflow;

    modport master (
        output start, abort, count, ref_count, ref_freq,
        input  busy, done, result, div_by_zero, overflow
    );

    modport slave (
        input  start, abort, count, ref_count, ref_freq,
        output busy, done, result, div_by_zero, overflow
    );
endinterface

// File: rtl/clock_freq_calc.sv
// Converts a measured clock count into a frequency in MHz:
//   result = (count * ref_freq) / ref_count
// The block multiplies in one cycle. It then runs a restoring divider that
// produces one quotient bit per cycle.
//   pClk        clock; all logic runs on its rising edge
//   SoftReset_n asynchronous active-low reset
//   bus         clock_freq_calc_if.slave; carries the request, operands, status
//               and result (see the interface file)
// The result saturates to all ones on divide-by-zero or when the quotient does
// not fit in OUT_W bits. The matching flag is raised with the result.
module clock_freq_calc #(
    parameter int CNT_W  = 64,
    parameter int FREQ_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic                    pClk,
    input  logic                    SoftReset_n,
    clock_freq_calc_if.slave        bus
);
    localparam int P_W    = CNT_W + FREQ_W;
    localparam int ITER_W = $clog2(P_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               accept_s;

    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   ref_count_r;
    logic [FREQ_W-1:0]  ref_freq_r;
    logic [P_W-1:0]     prod_r;
    logic [P_W-1:0]     quot_r;
    logic [CNT_W-1:0]   rem_r;
    logic [ITER_W-1:0]  iter_r;
    logic               dbz_r;

    logic [CNT_W:0]     rem_shift_s;
    logic [CNT_W-1:0]   rem_sub_s;
    logic               rem_ge_s;
    logic               quot_ovf_s;

    logic               busy_r;
    logic               done_r;
    logic [OUT_W-1:0]   result_r;
    logic               div_by_zero_r;
    logic               overflow_r;

    // State register.
    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic. Abort takes priority over every other transition.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bus.abort) begin
                    state_nx_s = ST_IDLE;
                end else if (ref_count_r == {CNT_W{1'b0}}) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_DIV: begin
                if (bus.abort) begin
                    state_nx_s = ST_IDLE;
                end else if (iter_r == ITER_W'(1)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // One restoring-division step. Before the shift the partial remainder is
    // always below ref_count. The shifted value therefore needs one extra bit.
    // That carry bit only matters for the comparison. The difference always
    // fits back into CNT_W bits.
    always_comb begin
        rem_shift_s = {rem_r, prod_r[P_W-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, ref_count_r});
        rem_sub_s   = rem_shift_s[CNT_W-1:0] - ref_count_r;
        quot_ovf_s  = |quot_r[P_W-1:OUT_W];
    end

    // Operand capture, multiply and divide datapath.
    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            count_r     <= {CNT_W{1'b0}};
            ref_count_r <= {CNT_W{1'b0}};
            ref_freq_r  <= {FREQ_W{1'b0}};
            prod_r      <= {P_W{1'b0}};
            quot_r      <= {P_W{1'b0}};
            rem_r       <= {CNT_W{1'b0}};
            iter_r      <= {ITER_W{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        count_r     <= bus.count;
                        ref_count_r <= bus.ref_count;
                        ref_freq_r  <= bus.ref_freq;
                    end
                end
                ST_MUL: begin
                    prod_r <= {{FREQ_W{1'b0}}, count_r} * {{CNT_W{1'b0}}, ref_freq_r};
                    quot_r <= {P_W{1'b0}};
                    rem_r  <= {CNT_W{1'b0}};
                    iter_r <= ITER_W'(P_W);
                    dbz_r  <= (ref_count_r == {CNT_W{1'b0}});
                end
                ST_DIV: begin
                    prod_r <= {prod_r[P_W-2:0], 1'b0};
                    quot_r <= {quot_r[P_W-2:0], rem_ge_s};
                    rem_r  <= rem_ge_s ? rem_sub_s : rem_shift_s[CNT_W-1:0];
                    iter_r <= iter_r - ITER_W'(1);
                end
                default: begin
                    iter_r <= iter_r;
                end
            endcase
        end
    end

    // Registered status and result. Result and flags change only when a
    // calculation completes without an abort.
    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            result_r      <= {OUT_W{1'b0}};
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            if ((state_r == ST_DONE) && !bus.abort) begin
                done_r <= 1'b1;
                if (dbz_r) begin
                    result_r      <= {OUT_W{1'b1}};
                    div_by_zero_r <= 1'b1;
                    overflow_r    <= 1'b0;
                end else if (quot_ovf_s) begin
                    result_r      <= {OUT_W{1'b1}};
                    div_by_zero_r <= 1'b0;
                    overflow_r    <= 1'b1;
                end else begin
                    result_r      <= quot_r[OUT_W-1:0];
                    div_by_zero_r <= 1'b0;
                    overflow_r    <= 1'b0;
                end
            end else begin
                done_r <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.result      = result_r;
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_clock_freq_calc.sv
// Self-checking bench for clock_freq_calc. It runs directed scenarios and then
// randomized operands. Expected values come from a wide-arithmetic reference
// model.
module tb_clock_freq_calc;
    localparam int LAT     = 82;
    localparam int LAT_DBZ = 2;

    logic pClk;
    logic SoftReset_n;
    int   total;
    int   bad;

    clock_freq_calc_if bus ();

    clock_freq_calc dut (
        .pClk        (pClk),
        .SoftReset_n (SoftReset_n),
        .bus         (bus.slave)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    // Reference: frequency = count * ref_freq / ref_count, saturating at 32 bits.
    task automatic ref_model(input logic [63:0] c, input logic [63:0] r, input logic [15:0] f,
                             output logic [31:0] res, output logic dbz, output logic ovf);
        logic [127:0] p;
        logic [127:0] q;
        p = 128'(c) * 128'(f);
        if (r == 64'd0) begin
            res = 32'hFFFF_FFFF; dbz = 1'b1; ovf = 1'b0;
        end else begin
            q = p / 128'(r);
            dbz = 1'b0;
            if (q > 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF) begin
                res = 32'hFFFF_FFFF; ovf = 1'b1;
            end else begin
                res = q[31:0]; ovf = 1'b0;
            end
        end
    endtask

    // Request a calculation. On return we are just after the accepting edge.
    task automatic launch(input string tag, input logic [63:0] c, input logic [63:0] r, input logic [15:0] f);
        bus.count = c; bus.ref_count = r; bus.ref_freq = f;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
    endtask

    // Wait, with a cycle bound, for done. Then check latency, result, flags and pulse width.
    task automatic wait_done(input string tag, input int already, input int exp_lat,
                             input logic [31:0] er, input logic ed, input logic eo);
        int n;
        n = already;
        while (!bus.done && n < already + 300) begin
            tick();
            n++;
        end
        check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check_val({tag, "_res"}, 64'(bus.result), 64'(er));
        check_val({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
        check_val({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
        check_val({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        tick();
        check_val({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_model(input string tag, input logic [63:0] c, input logic [63:0] r, input logic [15:0] f);
        logic [31:0] er;
        logic ed;
        logic eo;
        ref_model(c, r, f, er, ed, eo);
        launch(tag, c, r, f);
        wait_done(tag, 0, (r == 64'd0) ? LAT_DBZ : LAT, er, ed, eo);
    endtask

    initial begin
        logic [63:0] c;
        logic [63:0] r;
        logic [15:0] f;
        int seen;
        total = 0;
        bad   = 0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.count = 64'd0; bus.ref_count = 64'd0; bus.ref_freq = 16'd0;
        SoftReset_n = 1'b1;
        #2 SoftReset_n = 1'b0;
        tick(); tick();
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_res", 64'(bus.result), 64'd0);
        check_val("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check_val("rst_ovf", 64'(bus.overflow), 64'd0);
        SoftReset_n = 1'b1;
        tick();

        // T1 nominal, T2 divide by zero, T3 overflow then recovery.
        run_model("t1", 64'd3125, 64'd10000, 16'd400);
        run_model("t2", 64'd5, 64'd0, 16'd400);
        run_model("t3a", 64'd1 << 40, 64'd1, 16'd400);
        run_model("t3b", 64'd3125, 64'd10000, 16'd400);

        // T4: a second start while busy, with different operands, is ignored.
        launch("t4", 64'd3125, 64'd10000, 16'd400);
        repeat (9) tick();
        bus.count = 64'd7; bus.ref_count = 64'd3; bus.ref_freq = 16'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("t4", 10, LAT, 32'd125, 1'b0, 1'b0);
        check_val("t4_no_second", 64'(bus.busy), 64'd0);

        // Abort and start together in IDLE: abort wins.
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check_val("abort_idle_busy", 64'(bus.busy), 64'd0);

        // T5: abort mid-divide. The previous divide-by-zero result must be held.
        run_model("t5pre", 64'd5, 64'd0, 16'd400);
        launch("t5", 64'd3125, 64'd10000, 16'd400);
        repeat (29) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_val("t5_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) seen++;
            tick();
        end
        check_val("t5_nodone", 64'(seen), 64'd0);
        check_val("t5_res_kept", 64'(bus.result), 64'hFFFF_FFFF);
        check_val("t5_dbz_kept", 64'(bus.div_by_zero), 64'd1);
        run_model("t5post", 64'd3125, 64'd10000, 16'd400);

        // T6: asynchronous reset in the middle of a divide.
        launch("t6", 64'd3125, 64'd10000, 16'd400);
        repeat (40) tick();
        SoftReset_n = 1'b0;
        #1;
        check_val("t6_busy", 64'(bus.busy), 64'd0);
        check_val("t6_res", 64'(bus.result), 64'd0);
        check_val("t6_done", 64'(bus.done), 64'd0);
        #2 SoftReset_n = 1'b1;
        tick();
        run_model("t6post", 64'd999, 64'd999, 16'd1);

        // Randomized operands over a wide range of magnitudes.
        for (int i = 0; i < 24; i++) begin
            c = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) begin
                r = 64'd0;
            end else begin
                r = ({$urandom, $urandom} >> $urandom_range(0, 63)) | 64'd1;
            end
            f = 16'($urandom_range(0, 65535));
            run_model("rnd", c, r, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
